mag_peak_hold: RTL and testbench

MAG_PEAK_HOLD -- requirements
Module: mag_peak_hold

---
 rtl/mag_peak_hold_if.sv | 44 ++++
 rtl/mag_peak_hold.sv | 213 +++++++++++++++++++++
 tb/tb_mag_peak_hold.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mag_peak_hold_if.sv
// -----------------------------------------------------------------------------
// mag_peak_hold_if
// Sample/peak bundle between an audio sample source and the peak-hold meter.
//
// Signals
//   smpl_in   [15:0] two's-complement audio sample
//   smpl_vld         single-cycle strobe qualifying smpl_in
//   clr              synchronous clear of peak, state and clip flag
//   peak      [14:0] unsigned held peak magnitude
//   peak_vld         one-cycle pulse when peak was updated for a valid sample
//   clip             sticky full-scale flag
//
// Modports
//   master : sample source / consumer of the peak (drives smpl_in, smpl_vld, clr)
//   slave  : the peak-hold meter (drives peak, peak_vld, clip)
// -----------------------------------------------------------------------------
interface mag_peak_hold_if;

    logic [15:0] smpl_in;
    logic        smpl_vld;
    logic        clr;
    logic [14:0] peak;
    logic        peak_vld;
    logic        clip;

    modport master (
        output smpl_in,
        output smpl_vld,
        output clr,
        input  peak,
        input  peak_vld,
        input  clip
    );

    modport slave (
        input  smpl_in,
        input  smpl_vld,
        input  clr,
        output peak,
        output peak_vld,
        output clip
    );

endinterface

// File: rtl/mag_peak_hold.sv
// -----------------------------------------------------------------------------
// mag_peak_hold
// Peak-hold level meter for a 16-bit two's-complement audio stream.
// Each valid sample is reduced to a 15-bit magnitude (stage 1), then compared
// against the held peak (stage 2). A new maximum is held for HOLD_SMPLS
// below-peak samples, after which the peak decays by peak>>DECAY_SHIFT
// (at least 1) per valid sample, never falling below the current sample.
// A sticky clip flag records any full-scale magnitude.
//
// Parameters
//   HOLD_SMPLS  below-peak valid samples held before decay starts (1..65535)
//   DECAY_SHIFT decay step is peak>>DECAY_SHIFT per valid sample (1..14)
//
// Ports
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  mag_peak_hold_if.slave: smpl_in/smpl_vld/clr in, peak/peak_vld/clip out
//
// Latency: peak/peak_vld reflect a sample 2 cycles after its smpl_vld.
// -----------------------------------------------------------------------------
module mag_peak_hold #(
    parameter int unsigned HOLD_SMPLS  = 1024,
    parameter int unsigned DECAY_SHIFT = 4
) (
    input  logic           clk,
    input  logic           rst,
    mag_peak_hold_if.slave bus
);

    localparam int unsigned     CNT_W     = $clog2(HOLD_SMPLS + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_SMPLS);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [14:0]      MAG_FULL  = 15'h7FFF;
    localparam logic [14:0]      MAG_ZERO  = 15'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Magnitude of a two's-complement sample; -32768 has no positive
    // counterpart in 16 bits, so it saturates to the largest magnitude.
    function automatic logic [14:0] calc_mag(input logic [15:0] s);
        logic [15:0] neg_v;
        neg_v = 16'd0 - s;
        if (s == 16'h8000) begin
            calc_mag = MAG_FULL;
        end else if (s[15]) begin
            calc_mag = neg_v[14:0];
        end else begin
            calc_mag = s[14:0];
        end
    endfunction

    // One decay step: subtract peak>>DECAY_SHIFT, but at least 1 so small
    // peaks still reach zero, and never undercut the current magnitude.
    function automatic logic [14:0] calc_decay(input logic [14:0] pk,
                                               input logic [14:0] mg);
        logic [14:0] step_v;
        logic [14:0] dec_v;
        step_v = pk >> DECAY_SHIFT;
        if (step_v == MAG_ZERO) begin
            step_v = 15'd1;
        end else begin
            step_v = step_v;
        end
        dec_v = pk - step_v;
        if (dec_v < mg) begin
            calc_decay = mg;
        end else begin
            calc_decay = dec_v;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Registers and next-state signals
    // -------------------------------------------------------------------------
    logic [14:0]      mag_r;
    logic             vld_r;

    logic [14:0]      peak_r;
    logic             peak_vld_r;
    logic             clip_r;
    logic [CNT_W-1:0] hold_cnt_r;
    state_t           state_r;

    logic [14:0]      peak_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    state_t           state_nxt_s;
    logic             clip_nxt_s;

    // -------------------------------------------------------------------------
    // Stage 1
    // -------------------------------------------------------------------------

    // Stage 1: capture magnitude and qualifier; clr drops the incoming sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r <= MAG_ZERO;
            vld_r <= 1'b0;
        end else if (bus.clr) begin
            mag_r <= MAG_ZERO;
            vld_r <= 1'b0;
        end else begin
            if (bus.smpl_vld) begin
                mag_r <= calc_mag(bus.smpl_in);
            end else begin
                mag_r <= mag_r;
            end
            vld_r <= bus.smpl_vld;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2
    // -------------------------------------------------------------------------

    assign cnt_inc_s = hold_cnt_r + CNT_ONE;

    // Stage 2 next-state: peak/hold-counter/state update for the staged sample.
    always_comb begin
        peak_nxt_s  = peak_r;
        cnt_nxt_s   = hold_cnt_r;
        state_nxt_s = state_r;
        clip_nxt_s  = clip_r | (mag_r == MAG_FULL);

        if (mag_r > peak_r) begin
            // New maximum in any state restarts the hold window.
            peak_nxt_s  = mag_r;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_HOLD;
        end else if (mag_r == peak_r) begin
            // Re-hitting a non-zero peak re-arms the hold window; in IDLE
            // (peak 0) a zero sample leaves everything alone.
            if (peak_r != MAG_ZERO) begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_HOLD;
            end else begin
                cnt_nxt_s   = hold_cnt_r;
                state_nxt_s = state_r;
            end
        end else begin
            case (state_r)
                ST_HOLD: begin
                    // The sample that completes the window switches to
                    // DECAY but does not yet lower the peak.
                    cnt_nxt_s = cnt_inc_s;
                    if (cnt_inc_s == HOLD_LAST) begin
                        state_nxt_s = ST_DECAY;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DECAY: begin
                    peak_nxt_s  = calc_decay(peak_r, mag_r);
                    state_nxt_s = ST_DECAY;
                end
                default: begin
                    // IDLE has peak 0, so mag < peak cannot occur here.
                    peak_nxt_s  = peak_r;
                    state_nxt_s = state_r;
                end
            endcase
        end

        // A peak that reaches zero always parks the FSM in IDLE.
        if (peak_nxt_s == MAG_ZERO) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Stage 2 registers: rst beats clr, clr beats any update; idle cycles hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_r     <= MAG_ZERO;
            peak_vld_r <= 1'b0;
            clip_r     <= 1'b0;
            hold_cnt_r <= CNT_ZERO;
            state_r    <= ST_IDLE;
        end else if (bus.clr) begin
            peak_r     <= MAG_ZERO;
            peak_vld_r <= 1'b0;
            clip_r     <= 1'b0;
            hold_cnt_r <= CNT_ZERO;
            state_r    <= ST_IDLE;
        end else if (vld_r) begin
            peak_r     <= peak_nxt_s;
            peak_vld_r <= 1'b1;
            clip_r     <= clip_nxt_s;
            hold_cnt_r <= cnt_nxt_s;
            state_r    <= state_nxt_s;
        end else begin
            peak_vld_r <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign bus.peak     = peak_r;
    assign bus.peak_vld = peak_vld_r;
    assign bus.clip     = clip_r;

endmodule

// File: tb/tb_mag_peak_hold.sv
// -----------------------------------------------------------------------------
// tb_mag_peak_hold
// Directed bench for mag_peak_hold with HOLD_SMPLS=4, DECAY_SHIFT=4.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_mag_peak_hold;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mag_peak_hold_if bus_if ();

    mag_peak_hold #(
        .HOLD_SMPLS  (4),
        .DECAY_SHIFT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one valid sample, then idle one cycle: on return the sample
    // has just been processed by stage 2.
    task automatic send(input logic [15:0] s);
        bus_if.smpl_in  = s;
        bus_if.smpl_vld = 1'b1;
        tick();
        bus_if.smpl_vld = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        bus_if.clr = 1'b1;
        tick();
        bus_if.clr = 1'b0;
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus_if.smpl_in  = 16'd0;
        bus_if.smpl_vld = 1'b0;
        bus_if.clr      = 1'b0;

        // Reset state
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_peak", 32'(bus_if.peak), 32'd0);
        check("rst_peak_vld", 32'(bus_if.peak_vld), 32'd0);
        check("rst_clip", 32'(bus_if.clip), 32'd0);
        check("rst_state", 32'(dut.state_r), 32'd0);

        // First sample after reset
        send(16'd1000);
        check("s1000_peak", 32'(bus_if.peak), 32'd1000);
        check("s1000_vld", 32'(bus_if.peak_vld), 32'd1);
        check("s1000_state", 32'(dut.state_r), 32'd1);
        check("s1000_clip", 32'(bus_if.clip), 32'd0);
        tick();
        check("novld_pulse", 32'(bus_if.peak_vld), 32'd0);
        check("novld_peak", 32'(bus_if.peak), 32'd1000);

        // Negative full scale saturates and sets sticky clip
        send(16'h8000);
        check("neg_fs_peak", 32'(bus_if.peak), 32'h7FFF);
        check("neg_fs_clip", 32'(bus_if.clip), 32'd1);
        for (int i = 0; i < 20; i++) send(16'd0);
        check("clip_sticky", 32'(bus_if.clip), 32'd1);

        do_clr();
        check("clr_peak", 32'(bus_if.peak), 32'd0);
        check("clr_clip", 32'(bus_if.clip), 32'd0);
        check("clr_state", 32'(dut.state_r), 32'd0);

        // Hold window of 4, then decay 1024 -> 960 -> 900
        send(16'd1024);
        for (int i = 1; i <= 4; i++) begin
            send(16'd0);
            check("hold_peak", 32'(bus_if.peak), 32'd1024);
        end
        check("hold_to_decay", 32'(dut.state_r), 32'd2);
        send(16'd0);
        check("decay_960", 32'(bus_if.peak), 32'd960);
        send(16'd0);
        check("decay_900", 32'(bus_if.peak), 32'd900);

        // Small peak decays by the minimum step of 1 down to IDLE
        do_clr();
        send(16'd15);
        for (int i = 0; i < 4; i++) send(16'd0);
        check("p15_decay", 32'(dut.state_r), 32'd2);
        for (int i = 14; i >= 0; i--) begin
            send(16'd0);
            check("min_step", 32'(bus_if.peak), 32'(i));
        end
        check("to_idle", 32'(dut.state_r), 32'd0);
        send(16'd0);
        check("idle_zero_vld", 32'(bus_if.peak_vld), 32'd1);
        check("idle_zero_state", 32'(dut.state_r), 32'd0);

        // Equal-magnitude sample re-arms the hold window
        send(16'd500);
        for (int i = 0; i < 3; i++) send(16'd0);
        check("cnt3", 32'(dut.hold_cnt_r), 32'd3);
        check("cnt3_state", 32'(dut.state_r), 32'd1);
        send(16'hFE0C);
        check("rearm_cnt", 32'(dut.hold_cnt_r), 32'd0);
        check("rearm_peak", 32'(bus_if.peak), 32'd500);
        for (int i = 0; i < 3; i++) send(16'd0);
        check("rearm_still_hold", 32'(dut.state_r), 32'd1);
        send(16'd0);
        check("rearm_decay", 32'(dut.state_r), 32'd2);
        check("rearm_peak4", 32'(bus_if.peak), 32'd500);
        send(16'd0);
        check("decay_469", 32'(bus_if.peak), 32'd469);
        send(16'd460);
        check("decay_floor", 32'(bus_if.peak), 32'd460);

        // Positive full scale also clips; small negative magnitude
        do_clr();
        send(16'hFFFD);
        check("neg3_peak", 32'(bus_if.peak), 32'd3);
        send(16'd100);
        send(16'd32767);
        check("pos_fs_peak", 32'(bus_if.peak), 32'h7FFF);
        check("pos_fs_clip", 32'(bus_if.clip), 32'd1);

        // clr with a sample in stage 1 and a coincident sample: both dropped
        bus_if.smpl_in  = 16'd300;
        bus_if.smpl_vld = 1'b1;
        tick();
        bus_if.smpl_in  = 16'd2000;
        bus_if.clr      = 1'b1;
        tick();
        bus_if.clr      = 1'b0;
        bus_if.smpl_vld = 1'b0;
        check("clr_fl_peak", 32'(bus_if.peak), 32'd0);
        check("clr_fl_clip", 32'(bus_if.clip), 32'd0);
        check("clr_fl_vld", 32'(bus_if.peak_vld), 32'd0);
        tick();
        check("clr_fl_vld1", 32'(bus_if.peak_vld), 32'd0);
        check("clr_fl_peak1", 32'(bus_if.peak), 32'd0);
        tick();
        check("clr_fl_vld2", 32'(bus_if.peak_vld), 32'd0);
        check("clr_fl_peak2", 32'(bus_if.peak), 32'd0);

        // Reset mid-flight discards the staged sample; first sample after
        // reset is processed normally
        send(16'd3000);
        bus_if.smpl_in  = 16'd5000;
        bus_if.smpl_vld = 1'b1;
        tick();
        bus_if.smpl_vld = 1'b0;
        bus_if.clr      = 1'b1;
        rst             = 1'b1;
        tick();
        rst             = 1'b0;
        bus_if.clr      = 1'b0;
        check("rst_mid_peak", 32'(bus_if.peak), 32'd0);
        tick();
        check("rst_mid_vld", 32'(bus_if.peak_vld), 32'd0);
        check("rst_mid_peak2", 32'(bus_if.peak), 32'd0);
        send(16'd777);
        check("post_rst_peak", 32'(bus_if.peak), 32'd777);
        check("post_rst_vld", 32'(bus_if.peak_vld), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
